// File: rtl/apb_mm_pkg.sv
// Purpose : shared register map, bit positions and constants for the APB CSR block.
// Latency : n/a (constants and a pure helper function only).
// Backpressure: n/a.
package apb_mm_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam logic [15:0] TIMEOUT_RDATA   = 16'hDEAD;

  // Register indices
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_A_DATA  = 3'd2;
  localparam logic [2:0] REG_B_DATA  = 3'd3;
  localparam logic [2:0] REG_RESULT  = 3'd4;
  localparam logic [2:0] REG_RCOUNT  = 3'd5;
  localparam logic [2:0] REG_SCRATCH = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ERR_BIT   = 2;

  // Accesses that complete normally but read 0 and flag STATUS.err:
  // writes to read-only/reserved slots, reads of write-only slots.
  function automatic logic is_bad_access(input logic write, input logic [2:0] addr);
    if (write) return (addr == REG_RESULT) || (addr == REG_RCOUNT) || (addr == REG_RSVD);
    else       return (addr == REG_A_DATA) || (addr == REG_B_DATA);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Purpose : counts APB ACCESS wait states and flags a forced completion at TIMEOUT.
// Latency : expired_o is combinational from the registered count.
// Backpressure: none; it only observes the access/completion qualifiers.
// Ports   : clk_i/rst_i clock and sync reset; access_i qualified ACCESS cycle;
//           done_i transfer completes this cycle; expired_o wait limit reached.
module apb_wait_timer
  import apb_mm_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  logic done_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  // Counts only stalled ACCESS cycles; any completion or idle cycle clears it.
  // The count cannot pass TIMEOUT because reaching it forces done_i.
  always_comb begin
    cnt_d = 8'd0;
    if (access_i && !done_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = access_i && (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/apb_mm_csr.sv
// Purpose : APB CSR front-end for a compute core: operand streams out, result stream in.
// Latency : CSR slots zero wait states; stream slots complete with the stream handshake.
// Backpressure: pready follows a_ready/b_ready/r_valid; forced completion after TIMEOUT waits.
// Ports   : APB slave (pclk, preset, paddr, psel, penable, pwrite, pwdata, pready, prdata);
//           a_*/b_* operand streams out; r_* result stream in; start/busy/done/irq core control.
module apb_mm_csr
  import apb_mm_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned DW      = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic [2:0]    paddr,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [DW-1:0] pwdata,
  output logic          pready,
  output logic [DW-1:0] prdata,
  output logic          a_valid,
  output logic [DW-1:0] a_data,
  input  logic          a_ready,
  output logic          b_valid,
  output logic [DW-1:0] b_data,
  input  logic          b_ready,
  input  logic          r_valid,
  input  logic [DW-1:0] r_data,
  output logic          r_ready,
  output logic          start,
  input  logic          busy,
  input  logic          done,
  output logic          irq
);

  logic          xfer_q, xfer_d;
  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [15:0]   rcount_q, rcount_d;

  logic          access, expired, nat_rdy, cmpl, wr_ok, rd_ok;
  logic          is_a, is_b, is_r, start_req;
  logic [DW-1:0] rd_val, stat_val, ctrl_val;

  // xfer_q marks that a SETUP phase was seen since the last reset/completion, so an
  // ACCESS phase still held by the master across a reset is not acted upon.
  assign access = psel && penable && xfer_q && !preset;

  assign is_a = pwrite  && (paddr == REG_A_DATA);
  assign is_b = pwrite  && (paddr == REG_B_DATA);
  assign is_r = !pwrite && (paddr == REG_RESULT);

  always_comb begin
    nat_rdy = 1'b1;
    if (is_a)      nat_rdy = a_ready;
    else if (is_b) nat_rdy = b_ready;
    else if (is_r) nat_rdy = r_valid;
  end

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (pclk),
    .rst_i    (preset),
    .access_i (access),
    .done_i   (pready),
    .expired_o(expired)
  );

  assign pready  = access && (expired || nat_rdy);
  assign cmpl    = access && pready;
  assign wr_ok   = cmpl && pwrite;
  assign rd_ok   = cmpl && !pwrite;

  // A forced completion suppresses the stream handshake so no beat moves.
  assign a_valid = access && is_a && !expired;
  assign b_valid = access && is_b && !expired;
  assign r_ready = access && is_r && r_valid && !expired;
  assign a_data  = a_valid ? pwdata : '0;
  assign b_data  = b_valid ? pwdata : '0;

  always_comb begin
    ctrl_val = '0;
    ctrl_val[CTRL_IRQEN_BIT] = irq_en_q;
    stat_val = '0;
    stat_val[STAT_BUSY_BIT]  = busy;
    stat_val[STAT_DONE_BIT]  = done_q;
    stat_val[STAT_ERR_BIT]   = err_q;
    rd_val = '0;
    if (expired) rd_val = DW'(TIMEOUT_RDATA);
    else begin
      case (paddr)
        REG_CTRL:    rd_val = ctrl_val;
        REG_STATUS:  rd_val = stat_val;
        REG_RESULT:  rd_val = r_data;
        REG_RCOUNT:  rd_val = DW'(rcount_q);
        REG_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end
  end

  assign prdata = rd_ok ? rd_val : '0;

  assign start_req = wr_ok && (paddr == REG_CTRL) && pwdata[CTRL_START_BIT];

  always_comb begin
    xfer_d = xfer_q;
    if (!psel)        xfer_d = 1'b0;
    else if (!penable) xfer_d = 1'b1;
    else if (pready)  xfer_d = 1'b0;

    irq_en_d = irq_en_q;
    if (wr_ok && (paddr == REG_CTRL)) irq_en_d = pwdata[CTRL_IRQEN_BIT];

    start_d = start_req && !busy;

    // Sticky bits: a set event in the same cycle as a W1C wins.
    done_d = done_q;
    if (wr_ok && (paddr == REG_STATUS) && pwdata[STAT_DONE_BIT]) done_d = 1'b0;
    if (done) done_d = 1'b1;

    err_d = err_q;
    if (wr_ok && (paddr == REG_STATUS) && pwdata[STAT_ERR_BIT]) err_d = 1'b0;
    if ((cmpl && (expired || is_bad_access(pwrite, paddr))) || (start_req && busy))
      err_d = 1'b1;

    scratch_d = scratch_q;
    if (wr_ok && (paddr == REG_SCRATCH)) scratch_d = pwdata;

    rcount_d = rcount_q;
    if (start_q)                                        rcount_d = 16'd0;
    else if (r_valid && r_ready && rcount_q != 16'hFFFF) rcount_d = rcount_q + 16'd1;

    irq_d = done_q && irq_en_q;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      xfer_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      scratch_q <= '0;
      rcount_q  <= 16'd0;
    end else begin
      xfer_q    <= xfer_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      scratch_q <= scratch_d;
      rcount_q  <= rcount_d;
    end
  end

  assign start = start_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_apb_mm_csr.sv
// Purpose : scoreboard bench for apb_mm_csr with directed APB/stream/control vectors.
// Latency : stimulus and the completion monitor run as separate processes.
// Backpressure: stream readiness and r_valid are driven per vector.
module tb_apb_mm_csr;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [15:0] pwdata, prdata, a_data, b_data, r_data;
  logic        pready, a_valid, a_ready, b_valid, b_ready, r_valid, r_ready;
  logic        start, busy, done, irq;

  always #5 pclk = ~pclk;

  apb_mm_csr #(.TIMEOUT(15), .DW(16)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .start(start), .busy(busy), .done(done), .irq(irq)
  );

  typedef struct {
    logic [15:0] data;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [15:0] a_q[$];
  logic [15:0] b_q[$];

  int checks = 0;
  int errors = 0;
  int mon_waits = 0;
  int start_cnt = 0;
  int pop_cnt = 0;
  int rr_cnt = 0;
  exp_t  mon_e;
  string mon_nm;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the expected response whenever a transfer completes.
  always @(negedge pclk) begin
    if (start)             start_cnt++;
    if (r_ready)           rr_cnt++;
    if (r_valid && r_ready) pop_cnt++;
    if (a_valid && a_ready) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a-beat: unexpected beat %h", a_data);
      end else check("a-beat", a_data, a_q.pop_front());
    end
    if (b_valid && b_ready) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b-beat: unexpected beat %h", b_data);
      end else check("b-beat", b_data, b_q.pop_front());
    end
    if (psel && penable) begin
      if (pready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected-completion: addr %0d prdata %h", paddr, prdata);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_nm = name_q.pop_front();
          check({mon_nm, "-prdata"}, prdata, mon_e.data);
          check({mon_nm, "-waits"}, mon_waits, mon_e.waits);
        end
        mon_waits = 0;
      end else begin
        check("prdata-zero-in-wait", prdata, 0);
        mon_waits++;
      end
    end else mon_waits = 0;
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  // One APB transfer; called just after a rising edge, returns just after one.
  task automatic apb(input logic w, input logic [2:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input int exp_waits, input string nm);
    exp_t e;
    bit   ok;
    e.data  = w ? 16'h0 : exp_rd;
    e.waits = exp_waits;
    exp_q.push_back(e);
    name_q.push_back(nm);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = wd;
    tick();
    penable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge pclk);
      if (pready) begin ok = 1'b1; break; end
    end
    check({nm, "-completed"}, ok, 1);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 3'd0;
    pwdata = 16'h0; a_ready = 1'b1; b_ready = 1'b1; r_valid = 1'b0; r_data = 16'h0;
    busy = 1'b0; done = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset-outputs", {pready, prdata, start, irq, a_valid, b_valid, r_ready}, 0);
    tick();
    preset = 1'b0;
    tick();

    // Reset register state and zero-wait scratch round trip
    apb(0, 3'd0, 0, 16'h0000, 0, "ctrl-reset");
    apb(0, 3'd1, 0, 16'h0000, 0, "status-reset");
    apb(0, 3'd5, 0, 16'h0000, 0, "rcount-reset");
    apb(1, 3'd6, 16'h1234, 0, 0, "scratch-wr");
    apb(0, 3'd6, 0, 16'h1234, 0, "scratch-rd");

    // Operand A with 3 wait states, operand B with none
    a_ready = 1'b0;
    a_q.push_back(16'h00AB);
    fork
      apb(1, 3'd2, 16'h00AB, 0, 3, "a-write");
      begin repeat (4) @(posedge pclk); #1 a_ready = 1'b1; end
    join
    b_q.push_back(16'h0CD0);
    apb(1, 3'd3, 16'h0CD0, 0, 0, "b-write");

    // Result pop, then a timed-out result read
    r_valid = 1'b1; r_data = 16'h5A5A;
    apb(0, 3'd4, 0, 16'h5A5A, 0, "result-rd");
    r_valid = 1'b0; r_data = 16'h0;
    apb(0, 3'd5, 0, 16'h0001, 0, "rcount-one");
    apb(0, 3'd4, 0, 16'hDEAD, 15, "result-timeout");
    check("pops-after-timeout", pop_cnt, 1);
    check("rready-cycles", rr_cnt, 1);
    apb(0, 3'd1, 0, 16'h0004, 0, "status-err-timeout");
    apb(1, 3'd1, 16'h0004, 0, 0, "w1c-err");
    apb(0, 3'd1, 0, 16'h0000, 0, "status-cleared");

    // Illegal accesses complete normally, read 0 and flag err
    apb(1, 3'd7, 16'hFFFF, 0, 0, "rsvd-wr");
    apb(0, 3'd1, 0, 16'h0004, 0, "status-err-rsvd");
    apb(1, 3'd1, 16'h0004, 0, 0, "w1c-err2");
    apb(0, 3'd2, 0, 16'h0000, 0, "a-data-rd");
    apb(0, 3'd1, 0, 16'h0004, 0, "status-err-wo");
    apb(1, 3'd1, 16'h0004, 0, 0, "w1c-err3");

    // Start with irq enabled, then done pulse and irq
    apb(1, 3'd0, 16'h0003, 0, 0, "ctrl-start");
    tick(); tick();
    check("start-cycles", start_cnt, 1);
    apb(0, 3'd0, 0, 16'h0002, 0, "ctrl-readback");
    apb(0, 3'd5, 0, 16'h0000, 0, "rcount-cleared-by-start");
    done = 1'b1;
    tick();
    done = 1'b0;
    @(negedge pclk);
    check("irq-not-yet", irq, 0);
    tick();
    @(negedge pclk);
    check("irq-set", irq, 1);
    tick();
    apb(0, 3'd1, 0, 16'h0002, 0, "status-done");
    apb(1, 3'd1, 16'h0002, 0, 0, "w1c-done");
    tick();
    @(negedge pclk);
    check("irq-cleared", irq, 0);
    tick();

    // Start while busy: no pulse, err set, irq_en still written
    busy = 1'b1;
    apb(1, 3'd0, 16'h0001, 0, 0, "ctrl-start-busy");
    tick(); tick();
    check("no-start-when-busy", start_cnt, 1);
    apb(0, 3'd0, 0, 16'h0000, 0, "ctrl-irqen-off");
    apb(0, 3'd1, 0, 16'h0005, 0, "status-busy-err");
    fork
      apb(1, 3'd1, 16'h0002, 0, 0, "w1c-vs-done");
      begin tick(); done = 1'b1; tick(); done = 1'b0; end
    join
    apb(0, 3'd1, 0, 16'h0007, 0, "status-done-wins");
    busy = 1'b0;
    apb(1, 3'd1, 16'h0006, 0, 0, "w1c-both");
    apb(0, 3'd1, 0, 16'h0000, 0, "status-clear-all");
    check("irq-disabled", irq, 0);

    // One more pop so RCOUNT is non-zero before the reset
    r_valid = 1'b1; r_data = 16'h1111;
    apb(0, 3'd4, 0, 16'h1111, 0, "result-rd2");
    r_valid = 1'b0; r_data = 16'h0;
    apb(0, 3'd5, 0, 16'h0001, 0, "rcount-before-reset");

    // Reset during result-read wait states
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd4;
    tick();
    penable = 1'b1;
    repeat (3) tick();
    preset = 1'b1;
    tick();
    r_valid = 1'b1; r_data = 16'h2222;
    @(negedge pclk);
    check("rst-mid-outputs", {pready, prdata, start, irq, a_valid, b_valid, r_ready}, 0);
    tick();
    preset = 1'b0;
    @(negedge pclk);
    check("no-pop-after-reset", {pready, r_ready}, 0);
    tick();
    psel = 1'b0; penable = 1'b0; r_valid = 1'b0; r_data = 16'h0;
    tick();
    check("pop-count-final", pop_cnt, 2);
    apb(0, 3'd5, 0, 16'h0000, 0, "rcount-after-reset");
    apb(0, 3'd1, 0, 16'h0000, 0, "status-after-reset");
    apb(0, 3'd6, 0, 16'h0000, 0, "scratch-after-reset");
    tick();

    check("exp-queue-drained", exp_q.size(), 0);
    check("a-queue-drained", a_q.size(), 0);
    check("b-queue-drained", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mm_csr.md
APB_MM_CSR -- requirements
Module: apb_mm_csr

Interface
REQ-001 Parameter: TIMEOUT, 15, max ACCESS wait cycles before forced completion (range 1..255).
REQ-002 Parameter: DW, 16, APB and stream data width.
REQ-003 Clock, reset and APB ports:
  pclk  in  1  sole clock; all state on rising edge.
  preset  in  1  synchronous, active-high reset.
  paddr  in  3  register index.
  psel  in  1  slave select.
  penable  in  1  access phase.
  pwrite  in  1  1=write, 0=read.
  pwdata  in  DW  write data.
  pready  out  1  transfer complete.
  prdata  out  DW  read data.
REQ-004 Operand and result streams:
  a_valid  out  1  / a_data  out  DW / a_ready  in  1  operand-A stream to core.
  b_valid  out  1  / b_data  out  DW / b_ready  in  1  operand-B stream to core.
  r_valid  in  1  / r_data  in  DW / r_ready  out  1  result stream from core.
REQ-005 Control ports:
  start  out  1  one-cycle pulse.
  busy  in  1  core running.
  done  in  1  one-cycle pulse.
  irq  out  1  level interrupt.

Function
REQ-006 Register map: 0 CTRL RW (bit0 start self-clearing, reads 0; bit1 irq_en); 1 STATUS RO (bit0 busy, bit1 done sticky W1C, bit2 err sticky W1C, bits[15:3] 0); 2 A_DATA WO; 3 B_DATA WO; 4 RESULT RO; 5 RCOUNT RO; 6 SCRATCH RW; 7 reserved.
REQ-007 Transfer starts at psel&&!penable (SETUP); completes in the first ACCESS cycle with pready=1.
REQ-008 CSR addresses 0,1,5,6,7: pready=1 in the first ACCESS cycle; zero wait states.
REQ-009 prdata carries the read value only while psel&&penable&&!pwrite&&pready; otherwise 0.
REQ-010 A_DATA/B_DATA write: a_valid/b_valid=1, a_data/b_data=pwdata during ACCESS; pready=a_ready/b_ready combinationally; a beat is transferred exactly once, on the completing cycle.
REQ-011 RESULT read: r_ready=1 on the cycle r_valid=1 in ACCESS; prdata=r_data and pready=1 that cycle; exactly one pop per transfer.
REQ-012 Wait counter: increments on each ACCESS cycle with pready=0; clears on completion.
REQ-013 When the counter reaches TIMEOUT: pready=1, stream valid/ready held 0, prdata=16'hDEAD on reads, err set.
REQ-014 RCOUNT: 16-bit count of r_valid&&r_ready pops since the last start; saturates at 16'hFFFF; clears on start pulse.
REQ-015 CTRL write with bit0=1 and busy=0: start=1 on the cycle after completion, exactly one cycle.
REQ-016 CTRL write with bit0=1 and busy=1: no start pulse; err set; irq_en still updated.
REQ-017 done pulse sets STATUS.done; when it coincides with a W1C of done, set wins.
REQ-018 Writes to address 7, writes to RO registers and reads of WO registers complete normally, read 0 and set err.
REQ-019 irq = STATUS.done && irq_en, registered; asserts one cycle after done is set.

Reset
REQ-020 With preset=1 at an edge: pready, prdata, start, irq, a_valid, b_valid and r_ready are 0; CTRL, STATUS sticky bits, SCRATCH, RCOUNT and the wait counter are 0.
REQ-021 Reset mid-transfer abandons the transfer; no stream beat and no start pulse are produced after the reset edge.

Structure
REQ-022 Package apb_mm_pkg holds the register index constants, CTRL/STATUS bit positions, the 16'hDEAD timeout value and the TIMEOUT default.
REQ-023 Sub-module apb_wait_timer contains the wait counter and timeout compare.

Verification
REQ-024 Write 0x1234 to SCRATCH, then read it -> both transfers pready=1 in the first ACCESS cycle; prdata=0x1234.
REQ-025 Write A_DATA=0x00AB with a_ready low for 3 cycles -> 3 wait states; one a_valid&&a_ready beat carrying 0x00AB.
REQ-026 Read RESULT with r_valid held low, TIMEOUT=15 -> completion after 15 wait cycles; prdata=0xDEAD; STATUS.err=1; r_ready never high.
REQ-027 CTRL=0x3 with busy=0, then a done pulse -> start high for 1 cycle; STATUS=0x2; irq=1 next cycle; W1C 0x2 -> irq=0.
REQ-028 CTRL=0x1 with busy=1 -> no start pulse; STATUS.err=1. Then done pulse coincident with a W1C of done -> STATUS.done remains 1.
REQ-029 Assert preset during RESULT-read wait states -> all outputs 0 next cycle; RCOUNT=0; no pop.
